// File: rtl/gsu_register_file_if.sv
// Bus bundle for the GSU register file: core/host write ports, Y read port, taps and strobes.
interface gsu_register_file_if;
  logic [15:0] zbus;
  logic [3:0]  zsel;
  logic        z_wr_lo;
  logic        z_wr_hi;
  logic        pc_inc;
  logic        cpu_wr;
  logic [4:0]  cpu_addr;
  logic [7:0]  cpu_data;
  logic [3:0]  ysel;
  logic [15:0] ybus;
  logic [15:0] r00;
  logic [15:0] r01;
  logic [15:0] r07;
  logic [15:0] r08;
  logic [15:0] r15;
  logic        rom_reload;
  logic        go;
  logic        pc_written;

  modport master (
    output zbus, zsel, z_wr_lo, z_wr_hi, pc_inc, cpu_wr, cpu_addr, cpu_data, ysel,
    input  ybus, r00, r01, r07, r08, r15, rom_reload, go, pc_written
  );

  modport slave (
    input  zbus, zsel, z_wr_lo, z_wr_hi, pc_inc, cpu_wr, cpu_addr, cpu_data, ysel,
    output ybus, r00, r01, r07, r08, r15, rom_reload, go, pc_written
  );
endinterface

// File: rtl/gsu_register_file.sv
// GSU general register file R0..R15 with core/host byte-lane writes, PC increment and strobes.
// Optional macro GSU_REGFILE_BYPASS_EN forwards in-flight core write data to ybus and the taps.
module gsu_register_file #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             reset_n,
  gsu_register_file_if.slave bus
);

  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  logic [15:0] view_s [16];
  logic [15:0] host_lo_s;
  logic [15:0] host_hi_s;
  logic [15:0] core_lo_s;
  logic [15:0] core_hi_s;
  logic        r14_hit_s;
  logic        r15_hit_s;
  logic        go_d;
  logic        rom_reload_q;
  logic        go_q;
  logic        pc_written_q;

  // One-hot lane hit vectors per register for each write source
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      host_lo_s[i] = bus.cpu_wr  && (bus.cpu_addr[4:1] == 4'(i)) && !bus.cpu_addr[0];
      host_hi_s[i] = bus.cpu_wr  && (bus.cpu_addr[4:1] == 4'(i)) &&  bus.cpu_addr[0];
      core_lo_s[i] = bus.z_wr_lo && (bus.zsel == 4'(i));
      core_hi_s[i] = bus.z_wr_hi && (bus.zsel == 4'(i));
    end
    r14_hit_s = host_lo_s[14] | host_hi_s[14] | core_lo_s[14] | core_hi_s[14];
    r15_hit_s = host_lo_s[15] | host_hi_s[15] | core_lo_s[15] | core_hi_s[15];
    go_d      = bus.cpu_wr && (bus.cpu_addr == 5'b11111);
  end

  // Next-state merge: host lane beats core lane; any write on R15 suppresses the increment
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_d[i] = {host_hi_s[i] ? bus.cpu_data :
                   (core_hi_s[i] ? bus.zbus[15:8] : regs_q[i][15:8]),
                   host_lo_s[i] ? bus.cpu_data :
                   (core_lo_s[i] ? bus.zbus[7:0]  : regs_q[i][7:0])};
    end
    if (bus.pc_inc && !r15_hit_s) begin
      regs_d[15] = regs_q[15] + 16'd1;
    end else begin
      regs_d[15] = {host_hi_s[15] ? bus.cpu_data :
                    (core_hi_s[15] ? bus.zbus[15:8] : regs_q[15][15:8]),
                    host_lo_s[15] ? bus.cpu_data :
                    (core_lo_s[15] ? bus.zbus[7:0]  : regs_q[15][7:0])};
    end
  end

  // Read view seen by ybus and the taps
  always_comb begin
    for (int i = 0; i < 16; i++) begin
`ifdef GSU_REGFILE_BYPASS_EN
      // Only core lanes forward; host writes and pc_inc appear after the edge
      view_s[i] = {core_hi_s[i] ? bus.zbus[15:8] : regs_q[i][15:8],
                   core_lo_s[i] ? bus.zbus[7:0]  : regs_q[i][7:0]};
`else
      view_s[i] = regs_q[i];
`endif
    end
  end

  // Register array and one-cycle strobe flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= (i == 15) ? RESET_PC : 16'h0000;
      end
      rom_reload_q <= 1'b0;
      go_q         <= 1'b0;
      pc_written_q <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rom_reload_q <= r14_hit_s;
      go_q         <= go_d;
      pc_written_q <= r15_hit_s;
    end
  end

  assign bus.ybus       = view_s[bus.ysel];
  assign bus.r00        = view_s[0];
  assign bus.r01        = view_s[1];
  assign bus.r07        = view_s[7];
  assign bus.r08        = view_s[8];
  assign bus.r15        = view_s[15];
  assign bus.rom_reload = rom_reload_q;
  assign bus.go         = go_q;
  assign bus.pc_written = pc_written_q;

endmodule

// File: tb/tb_gsu_register_file.sv
// Scoreboard bench for gsu_register_file: a behavioural model pushes expectations, DUT outputs pop them.
module tb_gsu_register_file;

  localparam logic [15:0] RST_PC = 16'h8000;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  exp_t sb_q [$];
  logic [15:0] m_reg [16];

  gsu_register_file_if bif ();

  gsu_register_file #(.RESET_PC(RST_PC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs(input string tag);
    case (tag)
      "r00":   return bif.r00;
      "r01":   return bif.r01;
      "r07":   return bif.r07;
      "r08":   return bif.r08;
      "r15":   return bif.r15;
      "ybus":  return bif.ybus;
      "rom":   return {15'd0, bif.rom_reload};
      "go":    return {15'd0, bif.go};
      "pcw":   return {15'd0, bif.pc_written};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs(e.tag), e.val);
    end
  endtask

  task automatic idle(input logic [3:0] ys);
    bif.zbus = 16'h0000; bif.zsel = 4'h0; bif.z_wr_lo = 1'b0; bif.z_wr_hi = 1'b0;
    bif.pc_inc = 1'b0; bif.cpu_wr = 1'b0; bif.cpu_addr = 5'h00; bif.cpu_data = 8'h00;
    bif.ysel = ys;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
    m_reg[15] = RST_PC;
  endtask

  // Apply the currently driven inputs for one clock edge and check the result
  task automatic step();
    logic [15:0] nxt [16];
    logic        h14, h15, go_e;
    logic [3:0]  yidx;
    for (int i = 0; i < 16; i++) nxt[i] = m_reg[i];
    h15  = (bif.cpu_wr && bif.cpu_addr[4:1] == 4'hF) ||
           ((bif.z_wr_lo || bif.z_wr_hi) && bif.zsel == 4'hF);
    h14  = (bif.cpu_wr && bif.cpu_addr[4:1] == 4'hE) ||
           ((bif.z_wr_lo || bif.z_wr_hi) && bif.zsel == 4'hE);
    go_e = bif.cpu_wr && (bif.cpu_addr == 5'b11111);
    if (bif.pc_inc && !h15) nxt[15] = m_reg[15] + 16'h0001;
    if (bif.z_wr_lo) nxt[bif.zsel][7:0]  = bif.zbus[7:0];
    if (bif.z_wr_hi) nxt[bif.zsel][15:8] = bif.zbus[15:8];
    if (bif.cpu_wr) begin
      if (bif.cpu_addr[0]) nxt[bif.cpu_addr[4:1]][15:8] = bif.cpu_data;
      else                 nxt[bif.cpu_addr[4:1]][7:0]  = bif.cpu_data;
    end
    yidx = 4'($urandom_range(15));
    push("r00", nxt[0]);  push("r01", nxt[1]);  push("r07", nxt[7]);
    push("r08", nxt[8]);  push("r15", nxt[15]); push("ybus", nxt[yidx]);
    push("rom", {15'd0, h14}); push("go", {15'd0, go_e}); push("pcw", {15'd0, h15});
    @(posedge clk);
    #1;
    idle(yidx);
    #1;
    drain();
    for (int i = 0; i < 16; i++) m_reg[i] = nxt[i];
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      bif.ysel = 4'(i);
      #1;
      push("ybus", m_reg[i]);
      drain();
    end
    @(negedge clk);
  endtask

  task automatic core_wr(input logic [3:0] sel, input logic [15:0] d, input logic lo, input logic hi);
    bif.zsel = sel; bif.zbus = d; bif.z_wr_lo = lo; bif.z_wr_hi = hi;
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
    bif.cpu_wr = 1'b1; bif.cpu_addr = a; bif.cpu_data = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    idle(4'h0);
    model_reset();

    // Reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    push("r00", 16'h0000); push("r01", 16'h0000); push("r07", 16'h0000);
    push("r08", 16'h0000); push("r15", RST_PC);
    push("rom", 16'h0000); push("go", 16'h0000); push("pcw", 16'h0000);
    drain();
    @(negedge clk);
    reset_n = 1'b1;
    sweep();

    // R7 low-lane-only core write
    core_wr(4'd7, 16'h1234, 1'b1, 1'b1); step();
    core_wr(4'd7, 16'hA55A, 1'b1, 1'b0); step();
    chk("r07_lo_lane", bif.r07, 16'h125A);
    bif.ysel = 4'd7; #1;
    chk("ybus_r07", bif.ybus, 16'h125A);

    // PC wrap and write-over-increment
    core_wr(4'd15, 16'hFFFF, 1'b1, 1'b1); step();
    bif.pc_inc = 1'b1; step();
    chk("pc_wrap", bif.r15, 16'h0000);
    bif.pc_inc = 1'b1; step();
    chk("pc_inc1", bif.r15, 16'h0001);
    bif.pc_inc = 1'b1; core_wr(4'd15, 16'h0100, 1'b1, 1'b1); step();
    chk("pc_wr_wins", bif.r15, 16'h0100);
    chk("pcw_pulse", {15'd0, bif.pc_written}, 16'h0001);
    bif.pc_inc = 1'b1; step();
    chk("pcw_inc_only", {15'd0, bif.pc_written}, 16'h0000);

    // Host R15 byte writes and go
    host_wr(5'b11110, 8'h34); step();
    chk("go_lo_byte", {15'd0, bif.go}, 16'h0000);
    host_wr(5'b11111, 8'h12); step();
    chk("r15_host", bif.r15, 16'h1234);
    chk("go_hi_byte", {15'd0, bif.go}, 16'h0001);
    step();
    chk("go_single", {15'd0, bif.go}, 16'h0000);

    // rom_reload back-to-back and host low byte
    core_wr(4'd14, 16'h1111, 1'b1, 1'b1); step();
    core_wr(4'd14, 16'h2222, 1'b0, 1'b1); step();
    chk("rom_b2b", {15'd0, bif.rom_reload}, 16'h0001);
    host_wr(5'b11100, 8'h77); step();
    chk("rom_host", {15'd0, bif.rom_reload}, 16'h0001);
    step();
    chk("rom_clear", {15'd0, bif.rom_reload}, 16'h0000);

    // Same-cycle host hi + core both lanes on R3
    host_wr(5'b00111, 8'hAB); core_wr(4'd3, 16'h00CD, 1'b1, 1'b1); bif.ysel = 4'd3;
    #1;
`ifdef GSU_REGFILE_BYPASS_EN
    push("ybus", 16'h00CD);
`else
    push("ybus", m_reg[3]);
`endif
    drain();
    step();
    bif.ysel = 4'd3; #1;
    chk("r3_merge", bif.ybus, 16'hABCD);

    // Reset asserted mid-write drops the write
    core_wr(4'd5, 16'hBEEF, 1'b1, 1'b1); host_wr(5'b11111, 8'h99);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    push("r00", 16'h0000); push("r15", RST_PC); push("rom", 16'h0000);
    push("go", 16'h0000); push("pcw", 16'h0000);
    drain();
    idle(4'h5);
    reset_n = 1'b1;
    @(negedge clk);
    sweep();
    core_wr(4'd5, 16'hC0DE, 1'b1, 1'b1); step();
    bif.ysel = 4'd5; #1;
    chk("post_reset_wr", bif.ybus, 16'hC0DE);

    // Randomised traffic through the model
    for (int n = 0; n < 300; n++) begin
      bif.zsel     = ($urandom_range(3) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(15));
      bif.zbus     = 16'($urandom);
      bif.z_wr_lo  = 1'($urandom_range(1));
      bif.z_wr_hi  = 1'($urandom_range(1));
      bif.pc_inc   = 1'($urandom_range(1));
      bif.cpu_wr   = ($urandom_range(2) == 0);
      bif.cpu_addr = ($urandom_range(3) == 0) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(31));
      bif.cpu_data = 8'($urandom);
      step();
    end
    sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
